fft_input_buffer: RTL and testbench
===================================

FFT_INPUT_BUFFER -- requirements
Module: fft_input_buffer

Interface
REQ-001 Parameter WIDTH, default 26, packed complex word width {re[WIDTH-1:HALF_WIDTH], im[HALF_WIDTH-1:0]}, both halves signed two's complement.
REQ-002 Parameter N_POINTS, default 16, frame length; fixed at 16 (two radix-4 stages).
REQ-003 The block SHALL use one clock and asynchronous active-low reset.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 in_sample  input  HALF_WIDTH  signed real audio sample.
REQ-007 in_valid  input  1  in_sample valid.
REQ-008 in_ready  output  1  block accepts in_sample this cycle.
REQ-009 a, b, c, d  output  WIDTH each  butterfly operands for the current group.
REQ-010 out_valid  output  1  a..d valid.
REQ-011 out_ready  input  1  downstream radix-4 butterfly consumes a..d this cycle.
REQ-012 out_first  output  1  high with out_valid on group 0 of a frame.
REQ-013 out_last  output  1  high with out_valid on group 3 of a frame.

Function
REQ-014 Storage: two banks (ping-pong) of 16 WIDTH-bit words; per-bank full flag; write bank pointer wr_bank; read bank pointer rd_bank; 4-bit write count wr_cnt; 2-bit read group rd_grp.
REQ-015 Accepted sample is stored as {in_sample, HALF_WIDTH'b0}: real = sample, imag = 0.
REQ-016 Sample k of a frame (k = 4*k1 + k0) SHALL be written to address 4*k0 + k1 of wr_bank (radix-4 digit reversal).
REQ-017 Accept = in_valid && in_ready; in_ready = !full[wr_bank], combinational from registers only.
REQ-018 On accept with wr_cnt = 15: set full[wr_bank], toggle wr_bank, wr_cnt wraps to 0; otherwise wr_cnt increments.
REQ-019 out_valid = full[rd_bank]; a,b,c,d = words 4*rd_grp+0..3 of rd_bank, i.e. x[g], x[g+4], x[g+8], x[g+12] for g = rd_grp.
REQ-020 Outputs SHALL hold stable while out_valid && !out_ready.
REQ-021 On out_valid && out_ready: rd_grp increments; at rd_grp = 3, clear full[rd_bank], toggle rd_bank, rd_grp wraps to 0.
REQ-022 Latency: out_valid rises the cycle after the 16th sample of a frame is accepted, provided full[rd_bank] was clear.
REQ-023 Both banks full: in_ready = 0; the buffered sample is not dropped; writing resumes the cycle after the read side releases a bank.
REQ-024 Same-cycle frame completion on the write side and bank release on the read side SHALL both take effect; the flags are independent per bank.
REQ-025 No sample is lost or duplicated under any in_valid/out_ready pattern; frames emerge in arrival order.
REQ-026 out_first = out_valid && rd_grp == 0; out_last = out_valid && rd_grp == 3.

Reset
REQ-027 Asserting rst_n low SHALL immediately clear both full flags and zero wr_bank, rd_bank, wr_cnt and rd_grp; in_ready = 1, out_valid = out_first = out_last = 0.
REQ-028 Bank storage SHALL NOT be reset; a..d are don't-care while out_valid = 0.
REQ-029 Reset mid-frame SHALL discard partial and complete frames; the first sample after release is sample 0 of bank 0.

Structure
REQ-030 Shared package fft_pkg SHALL hold WIDTH, HALF_WIDTH, N_POINTS, the complex word typedef and the radix-4 digit-reverse function, for reuse by the butterfly and twiddle stages.
REQ-031 One sub-module, fft_pingpong_ram (2x16 words, one write port, four combinational read ports), is natural; control stays in fft_input_buffer.

Verification
REQ-032 Samples 0..15 with out_ready = 1 -> group 0 real parts 0,4,8,12; group 3 real parts 3,7,11,15; all imaginary parts 0; out_first on group 0, out_last on group 3.
REQ-033 in_sample = -100 as sample 0 -> a = {13'h1F9C, 13'h0000} on group 0.
REQ-034 out_ready = 0 while 32 samples are offered -> in_ready falls after 32 accepts; out_valid is held with a..d stable; after out_ready = 1 both frames emerge in order with no loss.
REQ-035 Frame 2 completes in the same cycle that frame 1's group-3 handshake occurs -> frame 2 output begins the next cycle; no stall and no data corruption.
REQ-036 rst_n pulsed low after 7 samples, then 16 new samples 100..115 -> first group real parts 100,104,108,112; none of the pre-reset data appears.
REQ-037 Random in_valid/out_ready for 100 frames -> scoreboard matches the digit-reversed reference ordering exactly.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared FFT definitions: word geometry, complex word type and radix-4 index helpers.
package fft_pkg;

    localparam int WIDTH      = 26;
    localparam int HALF_WIDTH = WIDTH / 2;
    localparam int N_POINTS   = 16;

    typedef struct packed {
        logic signed [HALF_WIDTH-1:0] re;
        logic signed [HALF_WIDTH-1:0] im;
    } cplx_t;

    // 16-point radix-4 digit reversal: k = 4*k1 + k0 maps to 4*k0 + k1.
    function automatic logic [3:0] digit_rev4(input logic [3:0] k);
        return {k[1:0], k[3:2]};
    endfunction

endpackage

// File: rtl/fft_input_buffer_if.sv
// Sample-in / butterfly-operand-out handshake bundle for fft_input_buffer.
interface fft_input_buffer_if #(
    parameter int WIDTH = fft_pkg::WIDTH
) ();
    localparam int HALF_WIDTH = WIDTH / 2;

    logic signed [HALF_WIDTH-1:0] in_sample;
    logic                         in_valid;
    logic                         in_ready;
    logic [WIDTH-1:0]             a;
    logic [WIDTH-1:0]             b;
    logic [WIDTH-1:0]             c;
    logic [WIDTH-1:0]             d;
    logic                         out_valid;
    logic                         out_ready;
    logic                         out_first;
    logic                         out_last;

    modport master (
        output in_sample, in_valid, out_ready,
        input  in_ready, a, b, c, d, out_valid, out_first, out_last
    );

    modport slave (
        input  in_sample, in_valid, out_ready,
        output in_ready, a, b, c, d, out_valid, out_first, out_last
    );
endinterface

// File: rtl/fft_pingpong_ram.sv
// Two 16-word banks, one synchronous write port, four combinational group read ports.
module fft_pingpong_ram #(
    parameter int WIDTH = fft_pkg::WIDTH
) (
    input  logic             clk,
    input  logic             we,
    input  logic             wr_bank,
    input  logic [3:0]       wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_bank,
    input  logic [1:0]       rd_grp,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] d
);

    logic [WIDTH-1:0] mem [32];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[{wr_bank, wr_addr}] <= wr_data;
        end
    end

    assign a = mem[{rd_bank, rd_grp, 2'd0}];
    assign b = mem[{rd_bank, rd_grp, 2'd1}];
    assign c = mem[{rd_bank, rd_grp, 2'd2}];
    assign d = mem[{rd_bank, rd_grp, 2'd3}];

endmodule

// File: rtl/fft_input_buffer.sv
// Ping-pong frame buffer: stores real samples digit-reversed, emits 4 operand groups per frame.
module fft_input_buffer #(
    parameter int WIDTH    = fft_pkg::WIDTH,
    parameter int N_POINTS = fft_pkg::N_POINTS
) (
    input  logic                clk,
    input  logic                rst_n,
    fft_input_buffer_if.slave   bus
);
    import fft_pkg::digit_rev4;

    localparam int HALF_WIDTH = WIDTH / 2;
    localparam int CNT_W      = $clog2(N_POINTS);

    logic [1:0]       full;
    logic             wr_bank;
    logic             rd_bank;
    logic [CNT_W-1:0] wr_cnt;
    logic [1:0]       rd_grp;

    logic accept;
    logic out_fire;
    logic frame_done;
    logic bank_release;

    always_comb begin
        bus.in_ready  = !full[wr_bank];
        bus.out_valid = full[rd_bank];
        bus.out_first = full[rd_bank] && (rd_grp == 2'd0);
        bus.out_last  = full[rd_bank] && (rd_grp == 2'd3);
        accept        = bus.in_valid && !full[wr_bank];
        out_fire      = full[rd_bank] && bus.out_ready;
        frame_done    = accept && (wr_cnt == CNT_W'(N_POINTS - 1));
        bank_release  = out_fire && (rd_grp == 2'd3);
    end

    // Set and clear can never target the same bank: set needs it empty, clear needs it full.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full    <= '0;
            wr_bank <= 1'b0;
            rd_bank <= 1'b0;
            wr_cnt  <= '0;
            rd_grp  <= '0;
        end else begin
            if (accept) begin
                wr_cnt <= wr_cnt + 1'b1;
                if (frame_done) begin
                    wr_bank <= ~wr_bank;
                end
            end
            if (out_fire) begin
                rd_grp <= rd_grp + 2'd1;
                if (bank_release) begin
                    rd_bank <= ~rd_bank;
                end
            end
            for (int unsigned i = 0; i < 2; i++) begin
                if (frame_done && (wr_bank == 1'(i))) begin
                    full[i] <= 1'b1;
                end else if (bank_release && (rd_bank == 1'(i))) begin
                    full[i] <= 1'b0;
                end
            end
        end
    end

    fft_pingpong_ram #(.WIDTH(WIDTH)) u_ram (
        .clk     (clk),
        .we      (accept),
        .wr_bank (wr_bank),
        .wr_addr (digit_rev4(wr_cnt)),
        .wr_data ({bus.in_sample, {HALF_WIDTH{1'b0}}}),
        .rd_bank (rd_bank),
        .rd_grp  (rd_grp),
        .a       (bus.a),
        .b       (bus.b),
        .c       (bus.c),
        .d       (bus.d)
    );

endmodule

// File: tb/tb_fft_input_buffer.sv
// Directed and random bench for fft_input_buffer with a frame-reordering scoreboard.
module tb_fft_input_buffer;

    localparam int W = 26;
    localparam int H = 13;

    typedef struct {
        logic [W-1:0] a, b, c, d;
        logic         first, last;
    } exp_t;

    logic clk;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    exp_t               expq[$];
    logic signed [H-1:0] fb[$];

    fft_input_buffer_if #(.WIDTH(W)) bus ();

    fft_input_buffer #(.WIDTH(W), .N_POINTS(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W-1:0] word(input logic [H-1:0] s);
        return {s, {H{1'b0}}};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Scoreboard: evaluated mid-cycle, predicts what the next rising edge will do.
    always @(negedge clk) begin
        exp_t e;
        int   pending;
        if (!rst_n) begin
            fb.delete();
            expq.delete();
        end else begin
            pending = (expq.size() + 3) / 4;
            checks++;
            assert (bus.in_ready === (pending < 2)) else begin
                errors++;
                $error("FAIL in_ready got=%0b exp=%0b", bus.in_ready, pending < 2);
            end
            checks++;
            assert (bus.out_valid === (expq.size() != 0)) else begin
                errors++;
                $error("FAIL out_valid got=%0b exp=%0b", bus.out_valid, expq.size() != 0);
            end
            if (bus.out_valid === 1'b1 && expq.size() != 0) begin
                e = expq[0];
                checks++;
                assert ({bus.a, bus.b, bus.c, bus.d, bus.out_first, bus.out_last}
                        === {e.a, e.b, e.c, e.d, e.first, e.last}) else begin
                    errors++;
                    $error("FAIL group got=%h/%h/%h/%h f%0b l%0b exp=%h/%h/%h/%h f%0b l%0b",
                           bus.a, bus.b, bus.c, bus.d, bus.out_first, bus.out_last,
                           e.a, e.b, e.c, e.d, e.first, e.last);
                end
                if (bus.out_ready) void'(expq.pop_front());
            end
            if (bus.in_valid && bus.in_ready) begin
                fb.push_back(bus.in_sample);
                if (fb.size() == 16) begin
                    for (int g = 0; g < 4; g++) begin
                        e.a = word(fb[g]);
                        e.b = word(fb[g+4]);
                        e.c = word(fb[g+8]);
                        e.d = word(fb[g+12]);
                        e.first = (g == 0);
                        e.last  = (g == 3);
                        expq.push_back(e);
                    end
                    fb.delete();
                end
            end
        end
    end

    task automatic send(input logic [H-1:0] s);
        bus.in_valid  = 1'b1;
        bus.in_sample = s;
        for (int t = 0; t < 500; t++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                @(posedge clk);
                #1;
                bus.in_valid = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        chk("send_timeout", 32'd1, 32'd0);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_valid();
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (bus.out_valid) return;
        end
        chk("wait_valid_timeout", 32'd1, 32'd0);
    endtask

    task automatic drain();
        bus.out_ready = 1'b1;
        for (int t = 0; t < 300 && expq.size() != 0; t++) idle(1);
        chk("drain_empty", expq.size(), 32'd0);
    endtask

    initial begin
        logic [W-1:0] neg_exp;
        bit           done;
        neg_exp = {13'h1F9C, 13'h0000};

        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_sample = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_first", bus.out_first, 0);
        chk("rst_out_last", bus.out_last, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Ramp 0..15 with the consumer always ready
        bus.out_ready = 1'b1;
        for (int i = 0; i < 16; i++) send(H'(i));
        wait_valid();
        chk("ramp_g0_first", bus.out_first, 1);
        chk("ramp_g0_a", bus.a, word(13'd0));
        chk("ramp_g0_d", bus.d, word(13'd12));
        drain();

        // Negative sample 0
        bus.out_ready = 1'b0;
        send(-13'sd100);
        for (int i = 1; i < 16; i++) send(H'(i));
        wait_valid();
        chk("neg_a", bus.a, neg_exp);
        drain();

        // Backpressure: 32 samples with consumer stalled
        bus.out_ready = 1'b0;
        for (int i = 0; i < 32; i++) send(H'(200 + i));
        @(negedge clk);
        chk("bp_in_ready_low", bus.in_ready, 0);
        chk("bp_out_valid", bus.out_valid, 1);
        bus.in_valid = 1'b1;
        bus.in_sample = H'(232);
        idle(5);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 16; i++) send(H'(232 + i));
        drain();

        // Frame completion coincides with group-3 release
        bus.out_ready = 1'b0;
        for (int i = 0; i < 28; i++) send(H'(300 + i));
        bus.out_ready = 1'b1;
        for (int i = 28; i < 32; i++) send(H'(300 + i));
        @(negedge clk);
        chk("coinc_out_valid", bus.out_valid, 1);
        chk("coinc_out_first", bus.out_first, 1);
        chk("coinc_a", bus.a, word(13'd316));
        drain();

        // Reset discards a full frame and a partial one
        bus.out_ready = 1'b0;
        for (int i = 0; i < 23; i++) send(H'(500 + i));
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_out_valid", bus.out_valid, 0);
        chk("mid_rst_in_ready", bus.in_ready, 1);
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 16; i++) send(H'(100 + i));
        wait_valid();
        chk("post_rst_a", bus.a, word(13'd100));
        chk("post_rst_b", bus.b, word(13'd104));
        chk("post_rst_c", bus.c, word(13'd108));
        chk("post_rst_d", bus.d, word(13'd112));
        drain();

        // Random valid/ready for 100 frames
        done = 1'b0;
        fork
            begin
                for (int f = 0; f < 100; f++) begin
                    for (int k = 0; k < 16; k++) begin
                        if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
                        send(H'($urandom_range(0, 8191)));
                    end
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1 bus.out_ready = ($urandom_range(0, 1) == 1);
                end
            end
        join
        drain();
        chk("final_partial", fb.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
